result_readout: RTL and testbench

- Reader side of the result register file.
- On a start command it sweeps the register file read select across a contiguous, wrapping range of result registers.
- Each 16-bit result is split into two bytes, MSB first, and streamed out over a valid/ready byte interface toward the host link.
- Optionally pulses the register file clear when the sweep completes.

---
 rtl/result_pkg.sv | 27 ++
 rtl/result_readout.sv | 124 ++++++++++++
 tb/tb_result_readout.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/result_pkg.sv
// Shared constants and FSM encoding for the result register file readout path.
// Widths here must match the register file that feeds rf_data.
package result_pkg;

   localparam int DATA_W   = 16;
   localparam int BYTE_W   = 8;
   localparam int NUM_REGS = 16;
   localparam int SEL_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND_HI,
      ST_SEND_LO,
      ST_CLEAR,
      ST_DONE
   } readout_state_t;

   // Requested counts above NUM_REGS read the whole file once.
   function automatic logic [SEL_W:0] clamp_count(input logic [SEL_W:0] n);
      if (n > (SEL_W+1)'(NUM_REGS)) begin
         return (SEL_W+1)'(NUM_REGS);
      end
      return n;
   endfunction

endpackage

// File: rtl/result_readout.sv
// Sweeps a wrapping range of result registers and streams each word MSB byte first
// over a valid/ready byte interface, optionally strobing the register file clear at the end.
module result_readout
   import result_pkg::*;
(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [SEL_W-1:0]    start_sel,
   input  logic [SEL_W:0]      num_regs,
   input  logic                clear_en,
   output logic [SEL_W-1:0]    out_sel,
   input  logic [DATA_W-1:0]   rf_data,
   output logic                clear_data,
   output logic [BYTE_W-1:0]   tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                done
);

   readout_state_t    state_q, state_d;
   logic [SEL_W-1:0]  index_q, index_d;
   logic [SEL_W:0]    remaining_q, remaining_d;
   logic              clear_flag_q, clear_flag_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [SEL_W:0]    count_clamped;

   assign count_clamped = clamp_count(num_regs);

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q      <= ST_IDLE;
         index_q      <= '0;
         remaining_q  <= '0;
         clear_flag_q <= 1'b0;
         word_q       <= '0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         remaining_q  <= remaining_d;
         clear_flag_q <= clear_flag_d;
         word_q       <= word_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (count_clamped == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH:   state_d = ST_SEND_HI;
         ST_SEND_HI: begin
            if (tx_ready) begin
               state_d = ST_SEND_LO;
            end
         end
         ST_SEND_LO: begin
            if (tx_ready) begin
               if (remaining_q == (SEL_W+1)'(1)) begin
                  state_d = clear_flag_q ? ST_CLEAR : ST_DONE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_CLEAR:   state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // The index doubles as the read select, so it only moves on the way into FETCH
   // and out_sel naturally holds its last value everywhere else.
   always_comb begin
      index_d      = index_q;
      remaining_d  = remaining_q;
      clear_flag_d = clear_flag_q;
      word_d       = word_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (count_clamped != '0)) begin
               index_d      = start_sel;
               remaining_d  = count_clamped;
               clear_flag_d = clear_en;
            end
         end
         ST_FETCH: word_d = rf_data;
         ST_SEND_LO: begin
            if (tx_ready && (remaining_q != (SEL_W+1)'(1))) begin
               remaining_d = remaining_q - (SEL_W+1)'(1);
               index_d     = index_q + SEL_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      out_sel    = index_q;
      tx_valid   = 1'b0;
      tx_data    = '0;
      clear_data = 1'b0;
      done       = 1'b0;
      busy       = (state_q != ST_IDLE);
      case (state_q)
         ST_SEND_HI: begin
            tx_valid = 1'b1;
            tx_data  = word_q[DATA_W-1:BYTE_W];
         end
         ST_SEND_LO: begin
            tx_valid = 1'b1;
            tx_data  = word_q[BYTE_W-1:0];
         end
         ST_CLEAR: clear_data = 1'b1;
         ST_DONE:  done       = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_result_readout.sv
// Directed bench for result_readout: table of sweeps plus hand-written
// sequences for reset, backpressure and mid-sweep reset.
module tb_result_readout;
   import result_pkg::*;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              start;
   logic [SEL_W-1:0]  start_sel;
   logic [SEL_W:0]    num_regs;
   logic              clear_en;
   logic [SEL_W-1:0]  out_sel;
   logic [DATA_W-1:0] rf_data;
   logic              clear_data;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] rf [NUM_REGS];
   int total = 0;
   int bad   = 0;

   assign rf_data = rf[out_sel];

   always #5 clk = ~clk;

   result_readout dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .start_sel  (start_sel),
      .num_regs   (num_regs),
      .clear_en   (clear_en),
      .out_sel    (out_sel),
      .rf_data    (rf_data),
      .clear_data (clear_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   typedef struct {
      int    ss;
      int    nr;
      int    ce;
      int    exp_bytes;
      int    exp_done;   // cycle of done, counting the cycle after the start edge as 1
      int    exp_clear;  // cycle of clear_data, 0 when none expected
      string tag;
   } vec_t;

   vec_t vecs [6];

   task automatic run_sweep(input int ss, input int nr, input int ce, input int exp_bytes,
                            input int exp_done, input int exp_clear, input string tag);
      int nbytes, done_at, clear_at, clear_cnt, w, idx;
      logic [DATA_W-1:0] word;
      logic [BYTE_W-1:0] exp_b;
      nbytes = 0; done_at = 0; clear_at = 0; clear_cnt = 0;
      @(negedge clk);
      start_sel = SEL_W'(ss);
      num_regs  = (SEL_W+1)'(nr);
      clear_en  = ce[0];
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 200 && done_at == 0; c++) begin
         if (tx_valid && tx_ready) begin
            w    = nbytes / 2;
            idx  = (ss + w) % NUM_REGS;
            word = rf[idx];
            exp_b = (nbytes % 2 == 1) ? word[BYTE_W-1:0] : word[DATA_W-1:BYTE_W];
            $display("%s byte %0d sel=%0d data=0x%02h", tag, nbytes, out_sel, tx_data);
            chk({tag, " byte"}, int'(tx_data), int'(exp_b));
            if (nbytes % 2 == 0) chk({tag, " out_sel"}, int'(out_sel), idx);
            nbytes++;
         end
         if (clear_data) begin
            clear_cnt++;
            clear_at = c;
         end
         if (done) done_at = c;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk({tag, " byte_count"}, nbytes, exp_bytes);
      chk({tag, " done_cycle"}, done_at, exp_done);
      chk({tag, " clear_cycle"}, clear_at, exp_clear);
      chk({tag, " clear_pulses"}, clear_cnt, (exp_clear != 0) ? 1 : 0);
      @(posedge clk);
      #1;
      chk({tag, " done_width"}, int'(done), 0);
      chk({tag, " idle_busy"}, int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i * 16'h1357) ^ 16'hA5C3;
      rf[0] = 16'h1234;
      rf[1] = 16'hABCD;
      rf[2] = 16'h00FF;
      rf[5] = 16'h5AC3;

      vecs[0] = '{0,  3, 0,  6, 10, 0, "basic"};
      vecs[1] = '{14, 4, 0,  8, 13, 0, "wrap"};
      vecs[2] = '{3, 20, 0, 32, 49, 0, "clamp"};
      vecs[3] = '{0,  2, 1,  4,  8, 7, "clear"};
      vecs[4] = '{7,  0, 1,  0,  1, 0, "zero"};
      vecs[5] = '{15, 1, 1,  2,  5, 4, "single_clr"};

      n_rst = 1'b1; start = 1'b1; start_sel = 4'd9; num_regs = 5'd3;
      clear_en = 1'b1; tx_ready = 1'b1;

      // Reset wins over a held start.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rst busy", int'(busy), 0);
         chk("rst tx_valid", int'(tx_valid), 0);
         chk("rst done", int'(done), 0);
         chk("rst clear_data", int'(clear_data), 0);
         chk("rst out_sel", int'(out_sel), 0);
         chk("rst tx_data", int'(tx_data), 0);
      end
      start = 1'b0;
      n_rst = 1'b0;
      @(posedge clk);
      #1 chk("post_rst busy", int'(busy), 0);

      for (int v = 0; v < 6; v++) begin
         run_sweep(vecs[v].ss, vecs[v].nr, vecs[v].ce, vecs[v].exp_bytes,
                   vecs[v].exp_done, vecs[v].exp_clear, vecs[v].tag);
      end

      // Backpressure on the high byte, with an ignored start while busy.
      tx_ready = 1'b0;
      @(negedge clk);
      start_sel = 4'd0; num_regs = 5'd1; clear_en = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 10 && !tx_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("bp valid_reached", int'(tx_valid), 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp hold valid", int'(tx_valid), 1);
         chk("bp hold data", int'(tx_data), 8'h12);
         if (i == 1) begin
            start_sel = 4'd5; num_regs = 5'd2; start = 1'b1;
         end
         @(posedge clk);
         #1 start = 1'b0;
      end
      chk("bp stall data", int'(tx_data), 8'h12);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp lo valid", int'(tx_valid), 1);
      chk("bp lo data", int'(tx_data), 8'h34);
      @(posedge clk);
      #1 chk("bp done", int'(done), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("bp no_requeue", int'(busy), 0);
      end

      // Reset during the low byte of the second word.
      @(negedge clk);
      start_sel = 4'd0; num_regs = 5'd3; clear_en = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      chk("midrst pre valid", int'(tx_valid), 1);
      chk("midrst pre data", int'(tx_data), 8'hCD);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst tx_valid", int'(tx_valid), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst out_sel", int'(out_sel), 0);
      n_rst = 1'b0;
      run_sweep(5, 1, 0, 2, 4, 0, "post_midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
